sram_fifo_fwft_stage: RTL and testbench
=======================================

# sram_fifo_fwft_stage

Output stage placed directly downstream of the BRAM-backed synchronous FIFO. The BRAM FIFO presents read data one cycle after its read enable. This block hides that latency. It pre-fetches words into a 2-entry register buffer and presents them to the consumer as first-word-fall-through: `data_o` is valid whenever `empty_o` is low, and `pop_i` consumes one word per cycle at full rate.

## Interface
- `DATA_WIDTH`, default 32: word width, identical on both sides.
- `clk_i`  in  1  clock; the single clock for this block and the upstream FIFO.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous flush; asserted in the same cycle as the upstream FIFO's flush/reset.
- `fifo_empty_i`  in  1  upstream BRAM FIFO EMPTY flag.
- `fifo_data_i`  in  DATA_WIDTH  upstream BRAM FIFO DO; valid in the cycle after `fifo_pop_o`.
- `fifo_pop_o`  out  1  upstream read enable (RDEN).
- `data_o`  out  DATA_WIDTH  head word; registered.
- `empty_o`  out  1  high when no word is held.
- `pop_i`  in  1  consumer pops the head; effective only when `empty_o`=0.
- `usage_o`  out  2  words held in the buffer (0..2); excludes the in-flight read.
- `underflow_o`  out  1  sticky; set by `pop_i` while `empty_o`=1.

## Operation
- State:
  - `buf_q[0:1]`: ring of 2 entries.
  - `rd_ptr_q` and `wr_ptr_q`: 1 bit each, wrapping 1→0.
  - `count_q`: 0..2.
  - `inflight_q`: a read was issued last cycle.
  - `underflow_q`.
- `deq = pop_i & ~empty_o`.
- `occ = count_q + inflight_q`, 2-bit unsigned.
- `fifo_pop_o = ~fifo_empty_i & ~flush_i & ((occ - deq) < 2)`.
  - Combinational.
  - This rule never overruns the buffer.
  - It never issues a read to an empty upstream FIFO.
- Capture: when `inflight_q`=1, write `fifo_data_i` into `buf_q[wr_ptr_q]`, then advance `wr_ptr_q`.
- Dequeue: when `deq`=1, advance `rd_ptr_q`.
- `count_q` next value = `count_q + inflight_q - deq`.
  - A simultaneous capture and dequeue leaves the count unchanged.
  - A simultaneous capture and dequeue is legal at count 1 and at count 2.
- `data_o = buf_q[rd_ptr_q]`. `empty_o = (count_q == 0)`. `usage_o = count_q`.
- `inflight_q` next value = `fifo_pop_o`.
- Flush, in the cycle `flush_i`=1:
  - Next state clears `count_q`, both pointers and `inflight_q`.
  - `fifo_pop_o` is forced 0.
  - Any word arriving in the following cycle is not captured, because `inflight_q` is 0.
  - `deq` in a flush cycle is ignored; no underflow is flagged.
  - `underflow_q` is not cleared by flush.
- Underflow:
  - `pop_i`=1 with `empty_o`=1 (and no flush) sets `underflow_q`.
  - State is unchanged.
  - Only reset clears `underflow_q`.
- `buf_q` contents are not reset. `data_o` is don't-care while `empty_o`=1.

## Timing
- Reset (async assert, sync-released upstream) values:
  - `empty_o`=1, `usage_o`=0, `underflow_o`=0, `fifo_pop_o`=0.
  - `inflight_q`=0, pointers 0.
- Latency: upstream non-empty in cycle N with an idle buffer gives:
  - `fifo_pop_o`=1 in cycle N.
  - Capture at the end of N+1.
  - `empty_o`=0 and `data_o` valid in cycle N+2.
- Throughput: 1 word/cycle sustained once `occ`=2 and `pop_i` is held high. No bubbles while the upstream FIFO is non-empty.
- Backpressure: with `pop_i`=0, at most 2 reads are issued before `fifo_pop_o` stays low.
- Order: words leave in upstream FIFO order across pointer wrap.
- Reset asserted mid-stream:
  - All outputs return to their reset values immediately (asynchronous).
  - A read in flight is dropped.

## Test plan
- Reset: assert `rst_ni`=0 with `fifo_empty_i`=0 -> `fifo_pop_o`=0, `empty_o`=1, `usage_o`=0, `underflow_o`=0 throughout reset.
- Single word: upstream holds 0xA5A5_0001, `pop_i`=0 -> `fifo_pop_o` asserted for exactly 1 cycle; `empty_o`=0 and `data_o`=0xA5A5_0001 two cycles later; `usage_o`=1.
- Streaming: upstream holds 0x10..0x1F, `pop_i`=1 continuously -> `data_o` is 0x10, 0x11, …, 0x1F on 16 consecutive cycles starting 2 cycles after the first `fifo_pop_o`; no gaps.
- Backpressure and wrap: upstream holds 5 words 0x1..0x5, `pop_i`=0 for 10 cycles -> exactly 2 `fifo_pop_o` pulses, `usage_o`=2; then pop one word every other cycle -> outputs 0x1..0x5 in order, `usage_o` never exceeds 2.
- Flush with read in flight: `fifo_pop_o`=1 in cycle N, `flush_i`=1 in cycle N+1 (upstream also flushed) -> data returned in N+1 is not captured; `empty_o`=1 and `usage_o`=0 from N+2.
- Underflow: `pop_i`=1 while `empty_o`=1 -> `underflow_o`=1 from the next cycle and stays 1 through subsequent traffic and a flush; cleared only by `rst_ni`=0.

Source files
------------

// File: rtl/sram_fifo_fwft_stage_if.sv
// Handshake bundle between the BRAM FIFO, the FWFT output stage and its consumer.
// The stage takes the slave view; the surrounding logic or bench takes the master view.
interface sram_fifo_fwft_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  flush_i;
  logic                  fifo_empty_i;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  fifo_pop_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  empty_o;
  logic                  pop_i;
  logic [1:0]            usage_o;
  logic                  underflow_o;

  modport slave (
    input  flush_i, fifo_empty_i, fifo_data_i, pop_i,
    output fifo_pop_o, data_o, empty_o, usage_o, underflow_o
  );

  modport master (
    output flush_i, fifo_empty_i, fifo_data_i, pop_i,
    input  fifo_pop_o, data_o, empty_o, usage_o, underflow_o
  );
endinterface

// File: rtl/sram_fifo_fwft_stage.sv
// First-word-fall-through stage that hides the one-cycle read latency of a BRAM FIFO
// by prefetching into a 2-entry register ring.
module sram_fifo_fwft_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  sram_fifo_fwft_stage_if.slave         bus
);

  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic                  underflow_q, underflow_d;

  logic                  deq;
  logic                  capture;
  logic                  fifo_pop;
  logic [1:0]            occ;
  logic [1:0]            occ_after_deq;

  always_comb begin
    deq           = bus.pop_i & (count_q != 2'd0) & ~bus.flush_i;
    capture       = inflight_q & ~bus.flush_i;
    occ           = count_q + {1'b0, inflight_q};
    occ_after_deq = occ - {1'b0, deq};
    // Gated by rst_ni so no read is requested while the stage is held in reset.
    fifo_pop      = rst_ni & ~bus.fifo_empty_i & ~bus.flush_i & (occ_after_deq < 2'd2);

    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    inflight_d  = fifo_pop;
    underflow_d = underflow_q | (bus.pop_i & (count_q == 2'd0) & ~bus.flush_i);

    if (bus.flush_i) begin
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      count_d    = 2'd0;
      inflight_d = 1'b0;
    end else begin
      if (capture) wr_ptr_d = ~wr_ptr_q;
      if (deq)     rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, inflight_q} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      inflight_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      underflow_q <= underflow_d;
    end
  end

  // Data ring carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (capture) buf_q[wr_ptr_q] <= bus.fifo_data_i;
  end

  assign bus.fifo_pop_o  = fifo_pop;
  assign bus.data_o      = buf_q[rd_ptr_q];
  assign bus.empty_o     = (count_q == 2'd0);
  assign bus.usage_o     = count_q;
  assign bus.underflow_o = underflow_q;

endmodule

// File: tb/tb_sram_fifo_fwft_stage.sv
// Bench for sram_fifo_fwft_stage: behavioural BRAM FIFO upstream, a timing-aware
// word scoreboard, and directed plus random traffic.
module tb_sram_fifo_fwft_stage;

  typedef struct {
    logic [31:0] w;
    int          rdy;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [31:0] up_q[$];
  ent_t        exp_q[$];
  int          deq_cyc[$];
  bit          uf_m = 1'b0;
  bit          pop_seen = 1'b0;
  int          pop_cyc = 0;
  int          pulses = 0;

  sram_fifo_fwft_stage_if #(.DATA_WIDTH(32)) bus();

  sram_fifo_fwft_stage #(.DATA_WIDTH(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Upstream read-enable observer: a read seen in cycle N returns data in N+1.
  always @(negedge clk) begin
    pop_seen = bus.fifo_pop_o && rst_n;
    pop_cyc  = cyc;
    if (pop_seen) pulses++;
  end

  // Scoreboard monitor: a word read in cycle N is expected at the head from N+2.
  always @(negedge clk) begin : mon
    int vis;
    int infl;
    bit dq;
    bit exp_pop;
    if (!rst_n) begin
      check("rst_fifo_pop", 32'(bus.fifo_pop_o), 32'd0);
      check("rst_empty", 32'(bus.empty_o), 32'd1);
      check("rst_usage", 32'(bus.usage_o), 32'd0);
      check("rst_underflow", 32'(bus.underflow_o), 32'd0);
      exp_q.delete();
      uf_m = 1'b0;
    end else begin
      vis  = 0;
      infl = 0;
      foreach (exp_q[i]) begin
        if (exp_q[i].rdy <= cyc) vis++;
        else if (exp_q[i].rdy == cyc + 1) infl++;
      end
      check("empty", 32'(bus.empty_o), 32'(vis == 0));
      check("usage", 32'(bus.usage_o), 32'(vis));
      check("underflow", 32'(bus.underflow_o), 32'(uf_m));
      dq = bus.pop_i && (vis > 0) && !bus.flush_i;
      exp_pop = (up_q.size() != 0) && !bus.flush_i && ((vis + infl - int'(dq)) < 2);
      check("fifo_pop", 32'(bus.fifo_pop_o), 32'(exp_pop));
      if (dq) begin
        check("data", bus.data_o, exp_q[0].w);
        exp_q.pop_front();
        deq_cyc.push_back(cyc);
      end
      if (bus.pop_i && vis == 0 && !bus.flush_i) uf_m = 1'b1;
      if (bus.flush_i) exp_q.delete();
    end
  end

  task automatic step();
    bit          f;
    logic [31:0] w;
    ent_t        e;
    f = bus.flush_i;
    @(posedge clk);
    #1;
    if (rst_n && pop_seen && up_q.size() != 0) begin
      w = up_q.pop_front();
      bus.fifo_data_i = w;
      e.w   = w;
      e.rdy = pop_cyc + 2;
      exp_q.push_back(e);
    end else begin
      bus.fifo_data_i = $urandom;
    end
    if (f) begin
      up_q.delete();
      bus.flush_i = 1'b0;
    end
    bus.fifo_empty_i = (up_q.size() == 0);
  endtask

  task automatic push(input logic [31:0] w);
    up_q.push_back(w);
    bus.fifo_empty_i = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    bus.flush_i      = 1'b0;
    bus.pop_i        = 1'b0;
    bus.fifo_data_i  = '0;
    bus.fifo_empty_i = 1'b1;
    #1;
    // Reset with upstream non-empty: no read may be issued.
    push(32'hDEAD_BEEF);
    rst_n = 1'b0;
    repeat (3) step();
    up_q.delete();
    bus.fifo_empty_i = 1'b1;
    rst_n = 1'b1;
    step();

    // Single word.
    pulses = 0;
    push(32'hA5A5_0001);
    repeat (6) step();
    check("single_pulses", 32'(pulses), 32'd1);
    check("single_data", bus.data_o, 32'hA5A5_0001);
    check("single_usage", 32'(bus.usage_o), 32'd1);
    bus.pop_i = 1'b1;
    step();
    bus.pop_i = 1'b0;
    repeat (2) step();

    // Streaming 0x10..0x1F.
    deq_cyc.delete();
    n0 = cyc;
    for (int i = 0; i < 16; i++) push(32'h10 + i);
    repeat (2) step();
    bus.pop_i = 1'b1;
    repeat (20) step();
    bus.pop_i = 1'b0;
    check("stream_count", 32'(deq_cyc.size()), 32'd16);
    if (deq_cyc.size() == 16) begin
      check("stream_first", 32'(deq_cyc[0]), 32'(n0 + 2));
      check("stream_last", 32'(deq_cyc[15]), 32'(n0 + 17));
    end

    // Backpressure and pointer wrap.
    pulses = 0;
    deq_cyc.delete();
    for (int i = 1; i <= 5; i++) push(32'(i));
    repeat (10) step();
    check("bp_pulses", 32'(pulses), 32'd2);
    check("bp_usage", 32'(bus.usage_o), 32'd2);
    for (int i = 0; i < 6; i++) begin
      bus.pop_i = 1'b1;
      step();
      bus.pop_i = 1'b0;
      step();
    end
    check("bp_count", 32'(deq_cyc.size()), 32'd5);

    // Flush with a read in flight.
    push(32'hF100);
    push(32'hF101);
    push(32'hF102);
    step();
    bus.flush_i = 1'b1;
    step();
    check("flush_empty", 32'(bus.empty_o), 32'd1);
    check("flush_usage", 32'(bus.usage_o), 32'd0);
    repeat (3) step();

    // Underflow is sticky across traffic and flush, cleared only by reset.
    do_reset(2);
    check("uf_clear", 32'(bus.underflow_o), 32'd0);
    bus.pop_i = 1'b1;
    step();
    bus.pop_i = 1'b0;
    check("uf_set", 32'(bus.underflow_o), 32'd1);
    push(32'h77);
    push(32'h78);
    repeat (4) step();
    bus.flush_i = 1'b1;
    step();
    repeat (2) step();
    check("uf_sticky", 32'(bus.underflow_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("uf_rst", 32'(bus.underflow_o), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Random traffic including flushes and mid-stream resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0 && up_q.size() < 8) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) push($urandom);
      end
      bus.pop_i   = ($urandom_range(0, 99) < 60);
      bus.flush_i = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 299) == 0) do_reset(2);
      else step();
    end
    bus.pop_i = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
